// File: rtl/dice_pkg.sv
// Shared types and constants for the dice launcher sequencer.
// Pure declarations: no latency, no flow control.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    DECEL,
    SHOW
  } state_e;

  localparam logic [2:0] FACE_MIN  = 3'd1;
  localparam logic [2:0] FACE_MAX  = 3'd6;
  localparam logic [3:0] CODE_DASH = 4'd15;

  function automatic logic [2:0] next_face(input logic [2:0] face);
    return (face == FACE_MAX) ? FACE_MIN : face + 3'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: Tick pulses one cycle in every TICK_DIV, on the last count.
// Tick is decoded from the count register; no backpressure.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic Tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll-button sequencer: rolls the face while held, decelerates on release, freezes and pulses Done.
// Outputs registered; press reaches Rolling in 3 edges. Optional face/dash blink in SHOW via DICE_BLINK_EN.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int DECEL_STEPS = 3,
  parameter int BLINK_TICKS = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       RollBtn,
  output logic [3:0] BinOut,
  output logic       Rolling,
  output logic       Done
);

  if (TICK_DIV < 2 || DECEL_STEPS < 1 || DECEL_STEPS > 15 || BLINK_TICKS < 1) begin : g_param_check
    $error("dice_roll_ctrl: parameter out of range");
  end

  localparam logic [3:0] STEPS4 = 4'(DECEL_STEPS);

  logic tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Tick    (tick)
  );

  // Button synchronizer plus a delayed copy for edge detection.
  logic sync1_q, sync1_d;
  logic btn_s_q, btn_s_d;
  logic btn_d_q, btn_d_d;
  logic btn_press;
  logic btn_rel;

  always_comb begin
    sync1_d = RollBtn;
    btn_s_d = sync1_q;
    btn_d_d = btn_s_q;
  end

  assign btn_press = btn_s_q & ~btn_d_q;
  assign btn_rel   = ~btn_s_q & btn_d_q;

  state_e     state_q, state_d;
  logic [2:0] face_q, face_d;
  logic [3:0] interval_q, interval_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] step_q, step_d;
  logic [3:0] bin_out_q, bin_out_d;
  logic       rolling_q, rolling_d;
  logic       done_q, done_d;
  logic       blink_dash;

  always_comb begin
    state_d    = state_q;
    face_d     = face_q;
    interval_d = interval_q;
    wait_d     = wait_q;
    step_d     = step_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_press) state_d = ROLL;
      end
      ROLL: begin
        // A tick coinciding with release still advances before deceleration starts.
        if (tick) face_d = next_face(face_q);
        if (btn_rel) begin
          state_d    = DECEL;
          interval_d = 4'd1;
          wait_d     = '0;
          step_d     = '0;
        end
      end
      DECEL: begin
        if (btn_press) begin
          state_d    = ROLL;
          interval_d = '0;
          wait_d     = '0;
          step_d     = '0;
        end else if (tick) begin
          if (wait_q + 4'd1 == interval_q) begin
            face_d     = next_face(face_q);
            wait_d     = '0;
            interval_d = interval_q + 4'd1;
            step_d     = step_q + 4'd1;
            if (step_q + 4'd1 == STEPS4) begin
              state_d = SHOW;
              done_d  = 1'b1;
            end
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
      end
      SHOW: begin
        if (btn_press) state_d = ROLL;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DICE_BLINK_EN
  localparam int            BW           = $clog2(BLINK_TICKS + 1);
  localparam logic [2:0]    BLINK_HALVES = 3'd6;
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS);

  logic [BW-1:0] blink_tick_q, blink_tick_d;
  logic [2:0]    blink_half_q, blink_half_d;

  // Counters sit at zero outside SHOW so every entry starts a fresh blink on the face half.
  always_comb begin
    blink_tick_d = blink_tick_q;
    blink_half_d = blink_half_q;
    if (state_q != SHOW) begin
      blink_tick_d = '0;
      blink_half_d = '0;
    end else if (tick && blink_half_q != BLINK_HALVES) begin
      if (blink_tick_q + BW'(1) == BLINK_LAST) begin
        blink_tick_d = '0;
        blink_half_d = blink_half_q + 3'd1;
      end else begin
        blink_tick_d = blink_tick_q + BW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_tick_q <= '0;
      blink_half_q <= '0;
    end else begin
      blink_tick_q <= blink_tick_d;
      blink_half_q <= blink_half_d;
    end
  end

  assign blink_dash = blink_half_d[0];
`else
  assign blink_dash = 1'b0;
`endif

  always_comb begin
    bin_out_d = CODE_DASH;
    if (state_d != IDLE && !(state_d == SHOW && blink_dash)) begin
      bin_out_d = {1'b0, face_d};
    end
    rolling_d = (state_d == ROLL) || (state_d == DECEL);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q    <= 1'b0;
      btn_s_q    <= 1'b0;
      btn_d_q    <= 1'b0;
      state_q    <= IDLE;
      face_q     <= FACE_MIN;
      interval_q <= '0;
      wait_q     <= '0;
      step_q     <= '0;
      bin_out_q  <= CODE_DASH;
      rolling_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      btn_s_q    <= btn_s_d;
      btn_d_q    <= btn_d_d;
      state_q    <= state_d;
      face_q     <= face_d;
      interval_q <= interval_d;
      wait_q     <= wait_d;
      step_q     <= step_d;
      bin_out_q  <= bin_out_d;
      rolling_q  <= rolling_d;
      done_q     <= done_d;
    end
  end

  assign BinOut  = bin_out_q;
  assign Rolling = rolling_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: directed vector table, reset corner cases, then random button activity vs a model.
module tb_dice_roll_ctrl;

  localparam int TD = 4;
  localparam int DS = 3;
  localparam int BT = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ROLL  = 1;
  localparam int M_DECEL = 2;
  localparam int M_SHOW  = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       RollBtn = 1'b0;
  logic [3:0] BinOut;
  logic       Rolling;
  logic       Done;

  int n_vec = 0;
  int n_err = 0;

  dice_roll_ctrl #(
    .TICK_DIV    (TD),
    .DECEL_STEPS (DS),
    .BLINK_TICKS (BT)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .RollBtn (RollBtn),
    .BinOut  (BinOut),
    .Rolling (Rolling),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  // Reference model: edges since reset give the tick phase, button history gives press/release,
  // deceleration advances when ticks-since-release hits a triangular number.
  int m_e, m_mode, m_face, m_dt, m_adv, m_st;
  bit m_p1, m_p2, m_p3, m_done;

  function automatic int tri_num(input int k);
    return k * (k + 1) / 2;
  endfunction

  task automatic model_reset();
    m_e = 0; m_mode = M_IDLE; m_face = 1; m_dt = 0; m_adv = 0; m_st = 0;
    m_p1 = 0; m_p2 = 0; m_p3 = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit b);
    bit pr, rl, tk;
    m_e++;
    tk = (m_e % TD) == 0;
    pr = m_p2 && !m_p3;
    rl = !m_p2 && m_p3;
    m_p3 = m_p2; m_p2 = m_p1; m_p1 = b;
    m_done = 0;
    case (m_mode)
      M_IDLE: if (pr) m_mode = M_ROLL;
      M_ROLL: begin
        if (tk) m_face = m_face % 6 + 1;
        if (rl) begin m_mode = M_DECEL; m_dt = 0; m_adv = 0; end
      end
      M_DECEL: begin
        if (pr) m_mode = M_ROLL;
        else if (tk) begin
          m_dt++;
          if (m_dt == tri_num(m_adv + 1)) begin
            m_face = m_face % 6 + 1;
            m_adv++;
            if (m_adv == DS) begin m_mode = M_SHOW; m_done = 1; m_st = 0; end
          end
        end
      end
      default: begin
        if (pr) m_mode = M_ROLL;
        else if (tk) m_st++;
      end
    endcase
  endtask

  function automatic int model_bin();
    if (m_mode == M_IDLE) return 15;
`ifdef DICE_BLINK_EN
    if (m_mode == M_SHOW && m_st < 6 * BT && ((m_st / BT) % 2) == 1) return 15;
`endif
    return m_face;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit b);
    RollBtn = b;
    @(posedge Clk);
    model_edge(b);
    #1;
  endtask

  // Reset is asserted mid-cycle and checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge Clk);
    RollBtn = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("reset_binout", BinOut, 15);
    chk("reset_rolling", Rolling, 0);
    chk("reset_done", Done, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit btn;
    int n;
    int bin;
    bit roll;
    bit done;
  } vec_t;

  vec_t tbl [31];

  initial begin
    bit b;
    int len;

    tbl[0]  = '{0, 50, 15, 0, 0};
    tbl[1]  = '{1,  2, 15, 0, 0};
    tbl[2]  = '{1,  1,  1, 1, 0};
    tbl[3]  = '{1,  2,  1, 1, 0};
    tbl[4]  = '{1,  1,  2, 1, 0};
    tbl[5]  = '{1, 16,  6, 1, 0};
    tbl[6]  = '{1,  4,  1, 1, 0};
    tbl[7]  = '{1, 12,  4, 1, 0};
    tbl[8]  = '{0,  3,  4, 1, 0};
    tbl[9]  = '{0,  1,  5, 1, 0};
    tbl[10] = '{0,  8,  6, 1, 0};
    tbl[11] = '{0, 11,  6, 1, 0};
    tbl[12] = '{0,  1,  1, 0, 1};
    tbl[13] = '{0,  1,  1, 0, 0};
    tbl[14] = '{0, 20,  1, 0, 0};
    tbl[15] = '{1,  3,  1, 1, 0};
    tbl[16] = '{1,  8,  3, 1, 0};
    tbl[17] = '{0,  4,  4, 1, 0};
    tbl[18] = '{1,  3,  4, 1, 0};
    tbl[19] = '{1,  1,  5, 1, 0};
    tbl[20] = '{0,  3,  5, 1, 0};
    tbl[21] = '{0,  1,  6, 1, 0};
    tbl[22] = '{0,  8,  1, 1, 0};
    tbl[23] = '{0, 11,  1, 1, 0};
    tbl[24] = '{0,  1,  2, 0, 1};
    tbl[25] = '{0,  1,  2, 0, 0};
    tbl[26] = '{1,  8,  3, 1, 0};
    tbl[27] = '{0,  3,  4, 1, 0};
    tbl[28] = '{0,  4,  5, 1, 0};
    tbl[29] = '{0, 19,  6, 1, 0};
    tbl[30] = '{0,  1,  1, 0, 1};

    model_reset();
    do_reset();

    for (int i = 0; i < 31; i++) begin
      repeat (tbl[i].n) step(tbl[i].btn);
      chk($sformatf("vec%0d_binout", i), BinOut, tbl[i].bin);
      chk($sformatf("vec%0d_rolling", i), Rolling, tbl[i].roll);
      chk($sformatf("vec%0d_done", i), Done, tbl[i].done);
    end

    // Reset while decelerating: immediate clear, no Done, next roll starts at face 1.
    repeat (12) step(1'b1);
    repeat (4) step(1'b0);
    chk("decel_before_reset_rolling", Rolling, 1);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      chk("post_reset_done", Done, 0);
      chk("post_reset_binout", BinOut, 15);
    end
    repeat (3) step(1'b1);
    chk("restart_binout", BinOut, 1);
    chk("restart_rolling", Rolling, 1);

    do_reset();
    b = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc += len) begin
      b = ~b;
      len = $urandom_range(1, 60);
      for (int k = 0; k < len; k++) begin
        step(b);
        chk("rand_binout", BinOut, model_bin());
        chk("rand_rolling", Rolling, (m_mode == M_ROLL || m_mode == M_DECEL) ? 1 : 0);
        chk("rand_done", Done, m_done);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
